// File: rtl/hilo_ctrl.sv
// hilo_ctrl -- sequencing controller for the MIPS HI/LO register pair.
//
// Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from EX, runs multiply and divide
// as 32-iteration shift-add / restoring-division loops, stalls the pipeline
// with busy while they run and drives the single 64-bit HI/LO write port.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   op_valid        EX holds a HI/LO operation (stable while busy)
//   op[2:0]         0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 ignored
//   src_a, src_b    rs / rt operands
//   flush           kill of the EX instruction, overrides everything
//   hilo_q[63:0]    current {HI,LO}
//   busy            pipeline stall request
//   hilo_we         HI/LO write enable
//   hilo_wdata      HI/LO write data {HI,LO}
//
// Build option: define HILO_FAST_MUL_EN for a single-cycle multiplier that
// takes MULT/MULTU straight from IDLE to DONE. Divide timing is unchanged.
module hilo_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid,
    input  logic [2:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        flush,
    input  logic [63:0] hilo_q,
    output logic        busy,
    output logic        hilo_we,
    output logic [63:0] hilo_wdata
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_DONE
    } state_t;

    state_t      state;
    logic [5:0]  cnt;
    logic [63:0] work;      // mul: {partial, multiplier}; div: {remainder, dividend}
    logic [31:0] opnd;      // mul: multiplicand; div: divisor
    logic        neg_res;   // product sign / quotient sign
    logic        neg_rem;   // remainder sign (dividend sign)
    logic        div_zero;
    logic [63:0] res;

    // ------------------------------------------------------------------
    // Decode and operand magnitudes
    // ------------------------------------------------------------------
    logic        is_mt, is_mul, is_div, signed_op;
    logic [31:0] mag_a, mag_b;

    always_comb begin
        is_mt     = (op == 3'd4) || (op == 3'd5);
        is_mul    = (op == 3'd0) || (op == 3'd1);
        is_div    = (op == 3'd2) || (op == 3'd3);
        signed_op = ~op[0];
        mag_a     = (signed_op && src_a[31]) ? (~src_a + 32'd1) : src_a;
        mag_b     = (signed_op && src_b[31]) ? (~src_b + 32'd1) : src_b;
    end

`ifdef HILO_FAST_MUL_EN
    // Sign-extending to 64 bits makes one unsigned multiply serve both MULT
    // and MULTU: the low 64 bits of the product are the same.
    logic [63:0] fast_prod;

    always_comb begin
        fast_prod = {{32{signed_op & src_a[31]}}, src_a} *
                    {{32{signed_op & src_b[31]}}, src_b};
    end
`else
    // ------------------------------------------------------------------
    // Shift-add multiply step: add multiplicand on multiplier LSB, shift
    // the 33-bit sum back into the top so the carry is not lost.
    // ------------------------------------------------------------------
    logic [32:0] mul_sum;
    logic [63:0] mul_next, mul_final;

    always_comb begin
        mul_sum   = {1'b0, work[63:32]} + (work[0] ? {1'b0, opnd} : 33'd0);
        mul_next  = {mul_sum, work[31:1]};
        mul_final = neg_res ? (~mul_next + 64'd1) : mul_next;
    end
`endif

    // ------------------------------------------------------------------
    // Restoring divide step. The remainder is always below the divisor,
    // so both the restored and subtracted values fit in 32 bits. A zero
    // divisor makes every trial succeed: the dividend magnitude shifts
    // into the remainder, and the sign fix then restores src_a exactly.
    // ------------------------------------------------------------------
    logic [32:0] rem_sh, rem_diff;
    logic        div_ge;
    logic [63:0] div_next;
    logic [31:0] quo_fix, rem_fix;

    always_comb begin
        rem_sh   = work[63:31];
        div_ge   = (rem_sh >= {1'b0, opnd});
        rem_diff = rem_sh - {1'b0, opnd};
        div_next = {(div_ge ? rem_diff[31:0] : rem_sh[31:0]), work[30:0], div_ge};
        if (div_zero)
            quo_fix = '1;
        else if (neg_res)
            quo_fix = ~div_next[31:0] + 32'd1;
        else
            quo_fix = div_next[31:0];
        rem_fix = neg_rem ? (~div_next[63:32] + 32'd1) : div_next[63:32];
    end

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            work     <= '0;
            opnd     <= '0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
            res      <= '0;
        end else if (flush) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (op_valid && is_mul) begin
`ifdef HILO_FAST_MUL_EN
                        res   <= fast_prod;
                        state <= S_DONE;
`else
                        work    <= {32'd0, mag_b};
                        opnd    <= mag_a;
                        neg_res <= signed_op & (src_a[31] ^ src_b[31]);
                        cnt     <= '0;
                        state   <= S_MUL;
`endif
                    end else if (op_valid && is_div) begin
                        work     <= {32'd0, mag_a};
                        opnd     <= mag_b;
                        neg_res  <= signed_op & (src_a[31] ^ src_b[31]);
                        neg_rem  <= signed_op & src_a[31];
                        div_zero <= (src_b == 32'd0);
                        cnt      <= '0;
                        state    <= S_DIV;
                    end
                end
                S_MUL: begin
`ifndef HILO_FAST_MUL_EN
                    work <= mul_next;
                    cnt  <= cnt + 6'd1;
                    if (cnt == 6'd31) begin
                        res   <= mul_final;
                        state <= S_DONE;
                    end
`else
                    state <= S_IDLE;
`endif
                end
                S_DIV: begin
                    work <= div_next;
                    cnt  <= cnt + 6'd1;
                    if (cnt == 6'd31) begin
                        res   <= {rem_fix, quo_fix};
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    // op_valid is ignored here so the completing op does not restart
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs: IDLE decisions are combinational from the request so the
    // stall and MTHI/MTLO write happen in the accept cycle.
    // ------------------------------------------------------------------
    always_comb begin
        busy       = 1'b0;
        hilo_we    = 1'b0;
        hilo_wdata = rst ? '0 : res;
        if (!rst && !flush) begin
            case (state)
                S_IDLE: begin
                    if (op_valid && is_mt) begin
                        hilo_we    = 1'b1;
                        hilo_wdata = (op == 3'd4) ? {src_a, hilo_q[31:0]}
                                                  : {hilo_q[63:32], src_a};
                    end else if (op_valid && (is_mul || is_div)) begin
                        busy = 1'b1;
                    end
                end
                S_MUL, S_DIV: busy = 1'b1;
                S_DONE:       hilo_we = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_ctrl.sv
// Self-checking bench for hilo_ctrl: table vectors from the known cases,
// randomized operations against an arithmetic reference model, and
// hand-written flush / reset sequences.
module tb_hilo_ctrl;

    logic        clk;
    logic        rst;
    logic        op_valid;
    logic [2:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        flush;
    logic [63:0] hilo_q;
    logic        busy;
    logic        hilo_we;
    logic [63:0] hilo_wdata;

    int unsigned vectors;
    int unsigned miscompares;

    hilo_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .op_valid   (op_valid),
        .op         (op),
        .src_a      (src_a),
        .src_b      (src_b),
        .flush      (flush),
        .hilo_q     (hilo_q),
        .busy       (busy),
        .hilo_we    (hilo_we),
        .hilo_wdata (hilo_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] hq;
        logic [63:0] exp;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: plain arithmetic on the architectural definition.
    function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a,
                                          input logic [31:0] b, input logic [63:0] hq);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            3'd0: begin p = sa * sb; return p; end
            3'd1: begin p = {32'd0, a} * {32'd0, b}; return p; end
            3'd2: begin
                if (b == 32'd0) return {a, 32'hFFFFFFFF};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            3'd3: begin
                if (b == 32'd0) return {a, 32'hFFFFFFFF};
                return {a % b, a / b};
            end
            3'd4: return {a, hq[31:0]};
            3'd5: return {hq[63:32], a};
            default: return 64'd0;
        endcase
    endfunction

    function automatic int unsigned latency(input logic [2:0] o);
`ifdef HILO_FAST_MUL_EN
        if (o <= 3'd1) return 1;
`endif
        return 33;
    endfunction

    // Issue one operation starting next cycle and check its whole life.
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] hq, input logic [63:0] exp, input string nm);
        int unsigned nb;
        bit done;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        op_valid = 1'b1;
        op       = o;
        src_a    = a;
        src_b    = b;
        hilo_q   = hq;
        if (o >= 3'd6) begin
            @(negedge clk);
            chk({nm, " ignored busy"}, {63'd0, busy}, 64'd0);
            chk({nm, " ignored we"}, {63'd0, hilo_we}, 64'd0);
            @(posedge clk);
            #1 op_valid = 1'b0;
            return;
        end
        if (o >= 3'd4) begin
            @(negedge clk);
            chk({nm, " mt busy"}, {63'd0, busy}, 64'd0);
            chk({nm, " mt we"}, {63'd0, hilo_we}, 64'd1);
            chk({nm, " mt data"}, hilo_wdata, exp);
            @(posedge clk);
            #1 op_valid = 1'b0;
            return;
        end
        nb   = 0;
        done = 1'b0;
        for (int c = 0; c < 100 && !done; c++) begin
            @(negedge clk);
            if (busy) begin
                nb++;
                chk({nm, " we while busy"}, {63'd0, hilo_we}, 64'd0);
            end else begin
                done = 1'b1;
            end
        end
        chk({nm, " completed"}, {63'd0, done}, 64'd1);
        chk({nm, " busy cycles"}, 64'(nb), 64'(latency(o)));
        chk({nm, " done we"}, {63'd0, hilo_we}, 64'd1);
        chk({nm, " done data"}, hilo_wdata, exp);
        // op_valid was still high in DONE; the op must not restart.
        @(posedge clk);
        #1 op_valid = 1'b0;
        @(negedge clk);
        chk({nm, " no restart busy"}, {63'd0, busy}, 64'd0);
        chk({nm, " no restart we"}, {63'd0, hilo_we}, 64'd0);
    endtask

    task automatic watch_no_we(input int unsigned n, input string nm);
        int unsigned pulses;
        pulses = 0;
        for (int unsigned c = 0; c < n; c++) begin
            @(negedge clk);
            if (hilo_we) pulses++;
        end
        chk(nm, 64'(pulses), 64'd0);
    endtask

    vec_t tbl[11];

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst      = 1'b1;
        op_valid = 1'b0;
        op       = 3'd0;
        src_a    = '0;
        src_b    = '0;
        flush    = 1'b0;
        hilo_q   = '0;

        tbl[0]  = '{3'd0, 32'hFFFFFFFD, 32'd5,        64'd0, 64'hFFFFFFFF_FFFFFFF1};
        tbl[1]  = '{3'd2, 32'hFFFFFFF9, 32'd2,        64'd0, 64'hFFFFFFFF_FFFFFFFD};
        tbl[2]  = '{3'd3, 32'd100,      32'd7,        64'd0, 64'h00000002_0000000E};
        tbl[3]  = '{3'd4, 32'h12345678, 32'd0, 64'hAAAAAAAA_BBBBBBBB, 64'h12345678_BBBBBBBB};
        tbl[4]  = '{3'd5, 32'h12345678, 32'd0, 64'hAAAAAAAA_BBBBBBBB, 64'hAAAAAAAA_12345678};
        tbl[5]  = '{3'd3, 32'h00000010, 32'd0,        64'd0, 64'h00000010_FFFFFFFF};
        tbl[6]  = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'd0, 64'hFFFFFFFE_00000001};
        tbl[7]  = '{3'd2, 32'hFFFFFFF0, 32'd0,        64'd0, 64'hFFFFFFF0_FFFFFFFF};
        tbl[8]  = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 64'd0, 64'h00000000_80000000};
        tbl[9]  = '{3'd2, 32'd7,        32'hFFFFFFFE, 64'd0, 64'h00000001_FFFFFFFD};
        tbl[10] = '{3'd6, 32'd1,        32'd1,        64'd0, 64'd0};

        // Reset state, both during and after reset.
        repeat (2) @(negedge clk);
        chk("rst busy", {63'd0, busy}, 64'd0);
        chk("rst we", {63'd0, hilo_we}, 64'd0);
        chk("rst data", hilo_wdata, 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("post rst busy", {63'd0, busy}, 64'd0);
        chk("post rst data", hilo_wdata, 64'd0);

        for (int i = 0; i < 11; i++)
            run_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].hq, tbl[i].exp,
                   $sformatf("tbl%0d", i));

        for (int i = 0; i < 40; i++) begin
            logic [2:0]  ro;
            logic [31:0] ra, rb;
            logic [63:0] rh;
            ro = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = ($urandom_range(0, 7) == 0) ? 32'd0 :
                 ($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 20)) : $urandom;
            rh = {$urandom, $urandom};
            run_op(ro, ra, rb, rh, model(ro, ra, rb, rh), $sformatf("rnd%0d", i));
        end

        // DIV flushed in cycle 10, MULT accepted the very next cycle.
        @(posedge clk);
        #1;
        op_valid = 1'b1; op = 3'd2; src_a = 32'd1000; src_b = 32'd3;
        repeat (10) @(posedge clk);
        #1 flush = 1'b1;
        @(negedge clk);
        chk("flush10 busy", {63'd0, busy}, 64'd0);
        chk("flush10 we", {63'd0, hilo_we}, 64'd0);
        run_op(3'd0, 32'hFFFFFFFD, 32'd5, 64'd0, 64'hFFFFFFFF_FFFFFFF1, "mult after flush");

        // Flush in DONE suppresses the write.
        @(posedge clk);
        #1;
        op_valid = 1'b1; op = 3'd3; src_a = 32'd100; src_b = 32'd7;
        repeat (33) @(posedge clk);
        #1 flush = 1'b1;
        @(negedge clk);
        chk("flush done busy", {63'd0, busy}, 64'd0);
        chk("flush done we", {63'd0, hilo_we}, 64'd0);
        @(posedge clk);
        #1; flush = 1'b0; op_valid = 1'b0;
        watch_no_we(40, "flush done no write");

        // Reset in cycle 20 abandons the divide.
        @(posedge clk);
        #1;
        op_valid = 1'b1; op = 3'd2; src_a = 32'hFFFFFFF9; src_b = 32'd2;
        repeat (20) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("rst20 busy", {63'd0, busy}, 64'd0);
        chk("rst20 we", {63'd0, hilo_we}, 64'd0);
        chk("rst20 data", hilo_wdata, 64'd0);
        @(posedge clk);
        #1; rst = 1'b0; op_valid = 1'b0;
        @(negedge clk);
        chk("rst20 after busy", {63'd0, busy}, 64'd0);
        chk("rst20 after data", hilo_wdata, 64'd0);
        watch_no_we(40, "rst20 no write");
        run_op(3'd1, 32'd6, 32'd7, 64'd0, 64'd42, "multu after rst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/hilo_ctrl.md
# hilo_ctrl

Sequencing controller for the HI/LO register pair of the MIPS core. Accepts HI/LO-writing operations from the EX stage: MULT, MULTU, DIV, DIVU, MTHI and MTLO. It runs multiply and divide as multi-cycle iterative operations and stalls the pipeline with `busy` while they run. It drives the single 64-bit write port of the HI/LO register. Sits between the EX-stage operand mux and the HI/LO register; `hilo_q` feeds back from that register.

## Interface
Parameters: none.
- `clk` in 1: clock.
- `rst` in 1: reset; synchronous, active-high.
- `op_valid` in 1: EX holds a HI/LO operation this cycle; held stable while `busy`.
- `op` in 3: operation code.
  - 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO.
  - 6 and 7 are ignored (no write, no busy).
- `src_a` in 32: rs operand (dividend / multiplicand / MT source).
- `src_b` in 32: rt operand (divisor / multiplier).
- `flush` in 1: exception/ERET kill of the EX instruction.
- `hilo_q` in 64: current HI/LO value, {HI,LO}.
- `busy` out 1: stall request to the pipeline.
- `hilo_we` out 1: write enable to HI/LO.
- `hilo_wdata` out 64: write data, {HI,LO}.

## Operation
- States: IDLE, MUL, DIV, DONE. Internal registers:
  - 6-bit iteration counter;
  - 64-bit working register;
  - 32-bit operand copy;
  - sign flags;
  - 64-bit result register `res`.
- IDLE:
  - MTHI/MTLO with `op_valid` and not `flush`: combinational write in the same cycle, no state change, `busy`=0.
    - MTHI writes {`src_a`, `hilo_q[31:0]`}.
    - MTLO writes {`hilo_q[63:32]`, `src_a`}.
  - MULT/MULTU with `op_valid` and not `flush`:
    - latch the operands; for MULT, latch the magnitudes and the sign flag (sign of the product).
    - clear the counter and go to MUL. `busy`=1 combinationally this cycle.
  - DIV/DIVU: same as MULT/MULTU but go to DIV. For DIV, record the quotient sign (a^b) and the remainder sign (sign of a).
- MUL:
  - shift-add one multiplier bit per cycle for 32 cycles.
  - on the last iteration, apply two's-complement negation if the sign flag is set, load `res`, go to DONE.
- DIV:
  - restoring division, one quotient bit per cycle, 32 cycles on unsigned magnitudes.
  - on the last iteration, fix the signs, load `res` = {remainder, quotient}, go to DONE.
- Divide by zero (`src_b`=0), both DIV and DIVU: `res` = {dividend `src_a`, 0xFFFFFFFF}.
  - The 32 cycles still elapse; latency is fixed.
- DONE: `hilo_we`=1, `hilo_wdata`=`res`, `busy`=0; go to IDLE next cycle. `op_valid` is ignored in DONE, so the completing instruction does not restart.
- `hilo_wdata` when not writing: `res`.
- `flush` overrides everything:
  - in any state, go to IDLE next cycle.
  - `hilo_we`=0 and `busy`=0 in the flush cycle; a flush in DONE suppresses the write.
- `rst` clears all registers, state to IDLE, outputs 0. Reset mid-operation abandons the operation with no write.

## Timing
- Reset values: `busy`=0, `hilo_we`=0, `hilo_wdata`=0, state IDLE.
- MTHI/MTLO: zero latency, written at the clock edge ending the accept cycle.
- MUL/DIV: accept at cycle 0, with `busy` high for cycles 0–32 (33 cycles).
  - `hilo_we` pulses in cycle 33 and the write takes effect at the end of cycle 33.
  - The next HI/LO op can be accepted in cycle 34.
- `busy` is combinational from `op_valid`/`op`/`flush` in IDLE and registered-state derived otherwise.

## Configuration
- `HILO_FAST_MUL_EN`:
  - When defined, MULT/MULTU use a single-cycle 32x32 signed/unsigned multiplier and bypass the MUL state. IDLE goes directly to DONE: `busy` is high for 1 cycle and `hilo_we` pulses in cycle 1.
  - When undefined, the MUL state iterates 32 cycles as above.
  - Divide timing is unaffected in both cases.

## Test plan
- MULT `src_a`=0xFFFFFFFD (−3), `src_b`=5 → `busy` high for 33 cycles (1 with `HILO_FAST_MUL_EN`), then one `hilo_we` pulse with 0xFFFFFFFF_FFFFFFF1.
- DIV −7/2 (0xFFFFFFF9, 2) → `hilo_wdata`=0xFFFFFFFF_FFFFFFFD (HI=−1, LO=−3) at cycle 33; DIVU 100/7 → 0x00000002_0000000E.
- MTHI 0x12345678 with `hilo_q`=0xAAAAAAAA_BBBBBBBB → same-cycle `hilo_we`, data 0x12345678_BBBBBBBB, `busy`=0.
  - MTLO with the same inputs → 0xAAAAAAAA_12345678.
- DIVU with divisor 0, dividend 0x00000010 → after 33 busy cycles, write 0x00000010_FFFFFFFF.
- DIV started, then `flush` at cycle 10 → `busy`=0 that cycle, no `hilo_we` ever, IDLE next cycle. A MULT accepted immediately after completes normally.
  - Repeat with `flush` in DONE: no write.
  - Repeat with `rst` at cycle 20: outputs 0, no write.
